// File: rtl/alu_wb_ctrl.sv
// Writeback controller downstream of the ALU: captures the result (immediately or after
// a multi-cycle shift), then offers it to the register file over valid/ready.
module alu_wb_ctrl #(
    parameter int WIDTH   = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [11:0]      decinst,
    input  logic [RD_W-1:0]  rd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cmp,
    input  logic             alu_carry,
    input  logic             alu_sl_ok,
    input  logic             wb_ready,
    output logic             wb_valid,
    output logic [RD_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_carry,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    typedef enum logic [1:0] {IDLE, WAIT_SL, HOLD} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t           r_state;
    logic [7:0]       r_count;
    logic             r_wbValid;
    logic [RD_W-1:0]  r_wbRd;
    logic [WIDTH-1:0] r_wbData;
    logic             r_wbCarry;
    logic             r_busy;
    logic             r_done;
    logic             r_timeoutErr;

    logic [2:0]       w_funct3;
    logic             w_isShift;
    logic [WIDTH-1:0] w_capData;

    assign w_funct3  = decinst[9:7];
    assign w_isShift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
    // SLT/SLTU write back the comparison flag zero-extended instead of the ALU word
    assign w_capData = ((w_funct3 == 3'b010) || (w_funct3 == 3'b011)) ?
                       {{(WIDTH-1){1'b0}}, alu_cmp} : alu_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_wbValid    <= 1'b0;
            r_wbRd       <= '0;
            r_wbData     <= '0;
            r_wbCarry    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_wbRd <= rd;
                        if (w_isShift) begin
                            r_state <= WAIT_SL;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                        end else if (rd == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_wbData  <= w_capData;
                            r_wbCarry <= alu_carry;
                            r_wbValid <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= HOLD;
                        end
                    end
                end
                WAIT_SL: begin
                    // A late sl_ok on the final allowed cycle still beats the timeout
                    if (alu_sl_ok) begin
                        if (r_wbRd == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_wbData  <= alu_result;
                            r_wbCarry <= alu_carry;
                            r_wbValid <= 1'b1;
                            r_state   <= HOLD;
                        end
                    end else if (r_count == LAST_COUNT) begin
                        r_timeoutErr <= 1'b1;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                HOLD: begin
                    if (wb_ready) begin
                        r_wbValid <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_valid    = r_wbValid;
    assign wb_rd       = r_wbRd;
    assign wb_data     = r_wbData;
    assign wb_carry    = r_wbCarry;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Self-checking bench for alu_wb_ctrl: transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_alu_wb_ctrl;

    localparam int WIDTH   = 32;
    localparam int RD_W    = 5;
    localparam int TIMEOUT = 40;

    localparam logic [11:0] OP_ADD = 12'b000000110011;
    localparam logic [11:0] OP_SUB = 12'b100000110011;
    localparam logic [11:0] OP_SLT = 12'b000100010011;
    localparam logic [11:0] OP_SRA = 12'b011010010011;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [11:0]      decinst;
    logic [RD_W-1:0]  rd;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cmp;
    logic             alu_carry;
    logic             alu_sl_ok;
    logic             wb_ready;
    logic             wb_valid;
    logic [RD_W-1:0]  wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             wb_carry;
    logic             busy;
    logic             done;
    logic             timeout_err;

    int compared   = 0;
    int mismatched = 0;

    alu_wb_ctrl #(.WIDTH(WIDTH), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .en(en), .decinst(decinst), .rd(rd),
        .alu_result(alu_result), .alu_cmp(alu_cmp), .alu_carry(alu_carry),
        .alu_sl_ok(alu_sl_ok), .wb_ready(wb_ready), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_carry(wb_carry), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Reference model: tracks one outstanding transaction as "waiting for a shift" or
    // "offered to the register file"; busy is whichever of those is true.
    bit               modelLive = 0;
    int               waited    = -1;
    logic             expValid  = 0;
    logic [RD_W-1:0]  expRd     = '0;
    logic [WIDTH-1:0] expData   = '0;
    logic             expCarry  = 0;
    logic             expDone   = 0;
    logic             expErr    = 0;

    always @(posedge clk) begin
        logic [2:0] f3;
        modelLive = 1;
        if (!reset) begin
            waited = -1; expValid = 0; expRd = '0; expData = '0;
            expCarry = 0; expDone = 0; expErr = 0;
        end else begin
            expDone = 0;
            if (waited >= 0) begin
                waited++;
                if (alu_sl_ok) begin
                    if (expRd != 0) begin
                        expData = alu_result; expCarry = alu_carry; expValid = 1;
                    end else begin
                        expDone = 1;
                    end
                    waited = -1;
                end else if (waited == TIMEOUT) begin
                    expErr = 1; expDone = 1; waited = -1;
                end
            end else if (expValid) begin
                if (wb_ready) begin
                    expValid = 0; expDone = 1;
                end
            end else if (en) begin
                expRd = rd;
                f3 = decinst[9:7];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    waited = 0;
                end else if (rd != 0) begin
                    expData  = (f3 == 3'd2 || f3 == 3'd3) ? {31'b0, alu_cmp} : alu_result;
                    expCarry = alu_carry;
                    expValid = 1;
                end else begin
                    expDone = 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("m_wb_valid", 32'(wb_valid), 32'(expValid));
            checkOutput("m_wb_rd", 32'(wb_rd), 32'(expRd));
            checkOutput("m_wb_data", wb_data, expData);
            checkOutput("m_wb_carry", 32'(wb_carry), 32'(expCarry));
            checkOutput("m_busy", 32'(busy), 32'((waited >= 0) || expValid));
            checkOutput("m_done", 32'(done), 32'(expDone));
            checkOutput("m_timeout_err", 32'(timeout_err), 32'(expErr));
        end
    end

    task automatic applyStimulus(input logic e, input logic [11:0] di, input logic [RD_W-1:0] r,
                                 input logic [WIDTH-1:0] res, input logic cmp, input logic cy,
                                 input logic sl, input logic rdy);
        en = e; decinst = di; rd = r; alu_result = res;
        alu_cmp = cmp; alu_carry = cy; alu_sl_ok = sl; wb_ready = rdy;
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 12'h0, 0, 32'h0, 0, 0, 0, 0);
        stepCycle(); stepCycle();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_data", wb_data, 32'd0);
        checkOutput("rst_err", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        stepCycle();

        // ADD, ready already high
        applyStimulus(1, OP_ADD, 5'd5, 32'hC040503F, 0, 0, 0, 1);
        stepCycle();
        checkOutput("add_valid", 32'(wb_valid), 32'd1);
        checkOutput("add_rd", 32'(wb_rd), 32'd5);
        checkOutput("add_data", wb_data, 32'hC040503F);
        applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 1);
        stepCycle();
        checkOutput("add_done", 32'(done), 32'd1);
        checkOutput("add_busy", 32'(busy), 32'd0);

        // SUB with ready withheld, plus an ignored mid-hold issue
        applyStimulus(1, OP_SUB, 5'd5, 32'hC0403041, 0, 1, 0, 0);
        stepCycle();
        checkOutput("sub_valid", 32'(wb_valid), 32'd1);
        checkOutput("sub_carry", 32'(wb_carry), 32'd1);
        applyStimulus(1, OP_ADD, 5'd7, 32'hDEADBEEF, 0, 0, 0, 0);
        stepCycle();
        checkOutput("sub_hold_data", wb_data, 32'hC0403041);
        checkOutput("sub_hold_rd", 32'(wb_rd), 32'd5);
        applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 0);
        stepCycle(); stepCycle();
        checkOutput("sub_valid4", 32'(wb_valid), 32'd1);
        checkOutput("sub_nodone", 32'(done), 32'd0);
        wb_ready = 1'b1;
        stepCycle();
        checkOutput("sub_release", 32'(wb_valid), 32'd0);
        checkOutput("sub_done", 32'(done), 32'd1);
        stepCycle();
        checkOutput("sub_done_pulse", 32'(done), 32'd0);

        // SLT returns the zero-extended compare flag
        applyStimulus(1, OP_SLT, 5'd3, 32'h12345678, 1, 0, 0, 1);
        stepCycle();
        checkOutput("slt_data", wb_data, 32'h00000001);
        applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 1);
        stepCycle();

        // SRA completing 6 cycles after issue
        applyStimulus(1, OP_SRA, 5'd8, 32'h0, 0, 0, 0, 1);
        stepCycle();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, OP_ADD, 5'd0, 32'h10000000 + 32'(i), 0, 0, 0, 1);
            stepCycle();
            checkOutput("sra_busy", 32'(busy), 32'd1);
            checkOutput("sra_novalid", 32'(wb_valid), 32'd0);
        end
        applyStimulus(0, OP_ADD, 5'd0, 32'hABCD0006, 0, 1, 1, 1);
        stepCycle();
        checkOutput("sra_data", wb_data, 32'hABCD0006);
        checkOutput("sra_valid", 32'(wb_valid), 32'd1);
        checkOutput("sra_err", 32'(timeout_err), 32'd0);
        applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 1);
        stepCycle();
        checkOutput("sra_done", 32'(done), 32'd1);

        // sl_ok on the very last allowed cycle: capture wins
        applyStimulus(1, OP_SRA, 5'd9, 32'h0, 0, 0, 0, 1);
        stepCycle();
        for (int i = 1; i < TIMEOUT; i++) begin
            applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 1);
            stepCycle();
        end
        applyStimulus(0, OP_ADD, 5'd0, 32'h5A5A5A5A, 0, 0, 1, 1);
        stepCycle();
        checkOutput("edge_valid", 32'(wb_valid), 32'd1);
        checkOutput("edge_data", wb_data, 32'h5A5A5A5A);
        checkOutput("edge_err", 32'(timeout_err), 32'd0);
        applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 1);
        stepCycle();

        // SRA whose sl_ok never comes
        applyStimulus(1, OP_SRA, 5'd10, 32'h0, 0, 0, 0, 1);
        stepCycle();
        for (int i = 1; i <= TIMEOUT; i++) begin
            applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 1);
            stepCycle();
            if (i < TIMEOUT) checkOutput("to_pending", 32'(timeout_err), 32'd0);
            checkOutput("to_novalid", 32'(wb_valid), 32'd0);
        end
        checkOutput("to_err", 32'(timeout_err), 32'd1);
        checkOutput("to_done", 32'(done), 32'd1);
        checkOutput("to_busy", 32'(busy), 32'd0);

        // rd = x0, then back-to-back issue while done is high
        applyStimulus(1, OP_ADD, 5'd0, 32'h11112222, 0, 0, 0, 1);
        stepCycle();
        checkOutput("x0_novalid", 32'(wb_valid), 32'd0);
        checkOutput("x0_done", 32'(done), 32'd1);
        applyStimulus(1, OP_ADD, 5'd3, 32'h33334444, 0, 0, 0, 1);
        stepCycle();
        checkOutput("b2b_valid", 32'(wb_valid), 32'd1);
        checkOutput("b2b_data", wb_data, 32'h33334444);
        applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 0);
        stepCycle();

        // Reset while holding
        applyStimulus(1, OP_ADD, 5'd4, 32'h77778888, 0, 1, 0, 0);
        stepCycle();
        checkOutput("rh_valid", 32'(wb_valid), 32'd1);
        applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 0);
        reset = 1'b0;
        stepCycle();
        checkOutput("rh_valid0", 32'(wb_valid), 32'd0);
        checkOutput("rh_busy0", 32'(busy), 32'd0);
        checkOutput("rh_data0", wb_data, 32'd0);
        checkOutput("rh_err0", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        applyStimulus(1, OP_ADD, 5'd6, 32'hC040503F, 0, 0, 0, 1);
        stepCycle();
        checkOutput("post_valid", 32'(wb_valid), 32'd1);
        checkOutput("post_rd", 32'(wb_rd), 32'd6);
        applyStimulus(0, OP_ADD, 5'd0, 32'h0, 0, 0, 0, 1);
        stepCycle();
        checkOutput("post_done", 32'(done), 32'd1);
        stepCycle(); stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_wb_ctrl.md
Name: alu_wb_ctrl

Overview:
- Writeback controller directly downstream of ALU_PROJECT.
- Takes the issue pulse and the decoded instruction, then waits for the ALU result (single-cycle ops or multi-cycle shifts gated by sl_ok).
- Registers the result and presents it to the register file over a valid/ready handshake.
- Raises busy to stall issue until the writeback completes.

Parameters:
- WIDTH, 32, datapath width of ALU result and writeback data
- RD_W, 5, destination register index width
- TIMEOUT, 40, maximum cycles spent in WAIT_SL before abort (range 2..255)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- en  input  1  issue pulse; same cycle as decinst/rd valid
- decinst  input  12  decoded instruction: [6:0] opcode, [9:7] funct3, [11:10] funct7 qualifiers
- rd  input  RD_W  destination register index
- alu_result  input  WIDTH  ALU SALIDA_Alu
- alu_cmp  input  1  ALU SALIDA_comparativa
- alu_carry  input  1  ALU carry
- alu_sl_ok  input  1  ALU shift-complete strobe
- wb_ready  input  1  register file accepts write
- wb_valid  output  1  write request
- wb_rd  output  RD_W  write index
- wb_data  output  WIDTH  write data
- wb_carry  output  1  carry captured with the result
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- timeout_err  output  1  sticky shift-timeout flag

Behaviour:
- Reset (reset==0 at a clock edge), including mid-operation:
  - state=IDLE, wb_valid=0, wb_rd=0, wb_data=0, wb_carry=0, busy=0, done=0, timeout_err=0, timeout counter=0.
  - A transaction in progress is dropped with no write.
- States: IDLE, WAIT_SL, HOLD.
- IDLE:
  - en=1 latches rd and classifies decinst[9:7].
  - funct3 001 or 101 (shifts): go to WAIT_SL with counter cleared.
  - Otherwise capture the result at this same edge and go to HOLD.
  - en is ignored in all other states.
- Result capture:
  - funct3 010/011 (SLT/SLTU): wb_data = {WIDTH-1 zeros, alu_cmp}.
  - All other funct3: wb_data = alu_result.
  - wb_carry = alu_carry in both cases.
- Single-cycle latency: en sampled at edge N → wb_valid=1 in the cycle after edge N.
- WAIT_SL:
  - Each cycle, if alu_sl_ok=1: capture alu_result, go to HOLD.
  - Otherwise increment the counter.
  - If the counter reaches TIMEOUT-1 with alu_sl_ok=0: set timeout_err, pulse done, return to IDLE, no write.
  - If alu_sl_ok=1 arrives on the same cycle the counter reaches TIMEOUT-1, the capture wins and no error is raised.
- HOLD:
  - wb_valid=1 with wb_rd and wb_data held stable until wb_ready=1.
  - Handshake edge (wb_valid & wb_ready): go to IDLE, done=1 for the following cycle, wb_valid=0.
  - wb_ready may be high before valid. The handshake completes on the first cycle both are high, giving a minimum HOLD of one cycle.
- rd==0: the result is discarded. Go straight from capture to IDLE with a done pulse, wb_valid never asserted. A shift to x0 still waits for sl_ok.
- Back-to-back issue: en is accepted in the same cycle done is high, because the state is IDLE then.
- timeout_err is cleared only by reset.
- Counter width is 8 bits and never wraps; it stops at TIMEOUT-1.

Test Plan:
- ADD: operando1=0xC0404040, rs2=0xFFF, alu_result=0xC040503F, decinst=12'b000000110011, rd=5, en 1 cycle, wb_ready=1 → wb_valid one cycle after en, wb_rd=5, wb_data=0xC040503F, done pulse, busy back to 0.
- SUB with wb_ready held 0 for 3 cycles: decinst=12'b100000110011, alu_result=0xC0403041 → wb_valid held 4 cycles with data stable; an en pulsed mid-hold is ignored; single done pulse after ready.
- SLT: decinst=12'b000100010011, alu_cmp=1, alu_result=0x12345678 → wb_data=0x00000001.
- SRA: decinst=12'b011010010011, alu_sl_ok asserted 6 cycles after en → busy high 6 cycles, wb_data = alu_result at the sl_ok cycle, timeout_err=0. Repeat with sl_ok never asserted → timeout_err=1 after 40 cycles, no wb_valid, done pulse.
- rd=0 ADD → no wb_valid, done pulse one cycle after capture.
- Reset=0 during HOLD → next cycle wb_valid=0, busy=0, wb_data=0; a subsequent ADD completes normally.
